// File: rtl/lif_neuron_core.sv
// Leaky integrate-and-fire neuron: integrates current_in on each step_en strobe,
// fires a one-cycle spike at threshold, then sits out a refractory period.
module lif_neuron_core #(
    parameter logic [7:0]  THRESHOLD     = 8'd200,
    parameter int unsigned LEAK_SHIFT    = 3,
    parameter int unsigned REFRACT_STEPS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step_en,
    input  logic [7:0] current_in,
    input  logic [7:0] thresh_in,
    output logic       spike,
    output logic [7:0] membrane,
    output logic       refractory,
    output logic [3:0] spike_count
);

    typedef enum logic [1:0] {
        ST_INTEGRATE = 2'd0,
        ST_FIRE      = 2'd1,
        ST_REFRACT   = 2'd2
    } state_t;

    localparam logic [3:0] REFRACT_INIT = 4'(REFRACT_STEPS);
    localparam logic [3:0] COUNT_MAX    = 4'd9;

    state_t     state_q, state_d;
    logic [7:0] membrane_q, membrane_d;
    logic [3:0] refract_cnt_q, refract_cnt_d;
    logic [3:0] spike_count_q, spike_count_d;
    logic       spike_q, spike_d;
    logic       refractory_q, refractory_d;

    logic [7:0] leak;
    logic [7:0] decayed;
    logic [8:0] sum9;
    logic [7:0] next_potential;
    logic [7:0] thr;
    logic       crosses;

    // decayed never exceeds the old membrane, so only the add can overflow;
    // the ninth bit catches it and the result clamps to full scale.
    always_comb begin
        leak           = membrane_q >> LEAK_SHIFT;
        decayed        = membrane_q - leak;
        sum9           = {1'b0, decayed} + {1'b0, current_in};
        next_potential = sum9[8] ? 8'hFF : sum9[7:0];
        thr            = (thresh_in == 8'd0) ? THRESHOLD : thresh_in;
        crosses        = (next_potential >= thr);
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a signal unassigned (no latch).
        state_d       = state_q;
        membrane_d    = membrane_q;
        refract_cnt_d = refract_cnt_q;
        spike_count_d = spike_count_q;

        unique case (state_q)
            ST_INTEGRATE: begin
                if (step_en) begin
                    if (crosses) begin
                        membrane_d    = 8'd0;
                        state_d       = ST_FIRE;
                        spike_count_d = (spike_count_q == COUNT_MAX) ? 4'd0
                                                                     : spike_count_q + 4'd1;
                    end else begin
                        membrane_d = next_potential;
                    end
                end
            end

            ST_FIRE: begin
                membrane_d = 8'd0;
                if (REFRACT_INIT == 4'd0) begin
                    state_d       = ST_INTEGRATE;
                    refract_cnt_d = 4'd0;
                end else begin
                    state_d       = ST_REFRACT;
                    refract_cnt_d = REFRACT_INIT;
                end
            end

            ST_REFRACT: begin
                membrane_d = 8'd0;
                if (step_en) begin
                    // The strobe that empties the counter only releases the
                    // neuron; its current is dropped.
                    if (refract_cnt_q <= 4'd1) begin
                        refract_cnt_d = 4'd0;
                        state_d       = ST_INTEGRATE;
                    end else begin
                        refract_cnt_d = refract_cnt_q - 4'd1;
                    end
                end
            end

            default: begin
                state_d       = ST_INTEGRATE;
                membrane_d    = 8'd0;
                refract_cnt_d = 4'd0;
            end
        endcase

        spike_d      = (state_d == ST_FIRE);
        refractory_d = (state_d == ST_REFRACT);
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values; reset is synchronous and wins over step_en.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_INTEGRATE;
            membrane_q    <= 8'd0;
            refract_cnt_q <= 4'd0;
            spike_count_q <= 4'd0;
            spike_q       <= 1'b0;
            refractory_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            membrane_q    <= membrane_d;
            refract_cnt_q <= refract_cnt_d;
            spike_count_q <= spike_count_d;
            spike_q       <= spike_d;
            refractory_q  <= refractory_d;
        end
    end

    assign spike       = spike_q;
    assign membrane    = membrane_q;
    assign refractory  = refractory_q;
    assign spike_count = spike_count_q;

endmodule

// File: tb/tb_lif_neuron_core.sv
// Directed and randomized bench for lif_neuron_core against a strobe-level
// behavioural model of the neuron.
module tb_lif_neuron_core;

    localparam int THR_DEF = 200;
    localparam int LEAK_SH = 3;
    localparam int REFR    = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       step_en = 1'b0;
    logic [7:0] current_in = 8'd0;
    logic [7:0] thresh_in = 8'd0;
    logic       spike;
    logic [7:0] membrane;
    logic       refractory;
    logic [3:0] spike_count;

    int checks = 0;
    int errors = 0;

    // Reference model: potential, pending fire, strobes left to sit out, decimal count.
    int m_mem   = 0;
    bit m_fire  = 1'b0;
    int m_left  = 0;
    int m_count = 0;

    lif_neuron_core #(
        .THRESHOLD    (8'(THR_DEF)),
        .LEAK_SHIFT   (LEAK_SH),
        .REFRACT_STEPS(REFR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .step_en    (step_en),
        .current_in (current_in),
        .thresh_in  (thresh_in),
        .spike      (spike),
        .membrane   (membrane),
        .refractory (refractory),
        .spike_count(spike_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_update(input bit se, input int cur, input int th, input bit rst);
        int nxt;
        int thr;
        if (rst) begin
            m_mem = 0; m_fire = 1'b0; m_left = 0; m_count = 0;
        end else if (m_fire) begin
            m_fire = 1'b0;
            m_left = REFR;
        end else if (m_left > 0) begin
            if (se) m_left = m_left - 1;
        end else if (se) begin
            nxt = m_mem - m_mem / (1 << LEAK_SH) + cur;
            if (nxt > 255) nxt = 255;
            thr = (th == 0) ? THR_DEF : th;
            if (nxt >= thr) begin
                m_mem   = 0;
                m_fire  = 1'b1;
                m_count = (m_count + 1) % 10;
            end else begin
                m_mem = nxt;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".membrane"},    {24'd0, membrane},    m_mem);
        check({tag, ".spike"},       {31'd0, spike},       {31'd0, m_fire});
        check({tag, ".refractory"},  {31'd0, refractory},  (m_left > 0) ? 1 : 0);
        check({tag, ".spike_count"}, {28'd0, spike_count}, m_count);
    endtask

    // One clock cycle: drive inputs, take the edge, compare just after it.
    task automatic cycle(input bit se, input int cur, input int th, input bit rst, input string tag);
        step_en    = se;
        current_in = cur[7:0];
        thresh_in  = th[7:0];
        reset      = rst;
        @(posedge clk);
        #1;
        step_en = 1'b0;
        reset   = 1'b0;
        model_update(se, cur, th, rst);
        check_all(tag);
    endtask

    initial begin
        int exp29 [5] = '{50, 94, 133, 167, 197};
        int th, r;

        cycle(1'b1, 50, 0, 1'b1, "reset0");
        cycle(1'b0, 0, 0, 1'b1, "reset1");
        check("reset.membrane", {24'd0, membrane}, 0);
        check("reset.spike_count", {28'd0, spike_count}, 0);

        for (int i = 0; i < 20; i++) cycle(1'b1, 0, 0, 1'b0, "zero_current");
        check("zero_current.final", {24'd0, membrane}, 0);

        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 50, 0, 1'b0, "ramp");
            check($sformatf("ramp_step%0d", i + 1), {24'd0, membrane}, exp29[i]);
            cycle(1'b0, 50, 0, 1'b0, "ramp_idle");
        end
        cycle(1'b1, 50, 0, 1'b0, "ramp_fire");
        check("ramp_fire.spike", {31'd0, spike}, 1);
        check("ramp_fire.count", {28'd0, spike_count}, 1);
        check("ramp_fire.membrane", {24'd0, membrane}, 0);

        cycle(1'b0, 50, 0, 1'b0, "fire_exit");
        check("fire_exit.refractory", {31'd0, refractory}, 1);
        check("fire_exit.spike", {31'd0, spike}, 0);
        cycle(1'b1, 50, 0, 1'b0, "refr_strobe1");
        check("refr_strobe1.membrane", {24'd0, membrane}, 0);
        check("refr_strobe1.refractory", {31'd0, refractory}, 1);
        cycle(1'b1, 50, 0, 1'b0, "refr_strobe2");
        check("refr_strobe2.membrane", {24'd0, membrane}, 0);
        cycle(1'b1, 50, 0, 1'b0, "refr_strobe3");
        check("refr_strobe3.membrane", {24'd0, membrane}, 50);

        cycle(1'b1, 255, 255, 1'b0, "saturate_fire");
        check("saturate_fire.spike", {31'd0, spike}, 1);
        cycle(1'b1, 255, 1, 1'b0, "strobe_in_fire");
        check("strobe_in_fire.refractory", {31'd0, refractory}, 1);
        cycle(1'b1, 0, 0, 1'b0, "sat_refr1");
        cycle(1'b1, 0, 0, 1'b0, "sat_refr2");

        cycle(1'b0, 0, 0, 1'b1, "count_reset");
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1, 1, 1, 1'b0, "count_fire");
            check($sformatf("count_seq%0d", i), {28'd0, spike_count}, i % 10);
            cycle(1'b0, 0, 0, 1'b0, "count_exit");
            cycle(1'b1, 0, 0, 1'b0, "count_refr1");
            cycle(1'b1, 0, 0, 1'b0, "count_refr2");
        end

        cycle(1'b1, 255, 1, 1'b0, "abort_fire");
        cycle(1'b0, 0, 0, 1'b0, "abort_exit");
        check("abort_exit.refractory", {31'd0, refractory}, 1);
        cycle(1'b1, 50, 0, 1'b1, "abort_reset");
        check("abort_reset.refractory", {31'd0, refractory}, 0);
        check("abort_reset.spike_count", {28'd0, spike_count}, 0);
        cycle(1'b1, 50, 0, 1'b0, "after_reset");
        check("after_reset.membrane", {24'd0, membrane}, 50);

        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 3);
            case (r)
                0:       th = 0;
                1:       th = $urandom_range(1, 8);
                2:       th = 255;
                default: th = $urandom_range(0, 255);
            endcase
            cycle(1'($urandom_range(0, 1)), $urandom_range(0, 255), th,
                  ($urandom_range(0, 59) == 0), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lif_neuron_core.md
LIF_NEURON_CORE -- requirements
Module: lif_neuron_core

Interface
REQ-001 SHALL have parameter THRESHOLD, default 8'd200: firing threshold used when thresh_in == 0.
REQ-002 SHALL have parameter LEAK_SHIFT, default 3: leak per step = membrane >> LEAK_SHIFT (range 1..7).
REQ-003 SHALL have parameter REFRACT_STEPS, default 2: number of step_en strobes ignored after a spike (range 0..15).
REQ-004 SHALL have port clk, input, 1: rising-edge clock for all state.
REQ-005 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port step_en, input, 1: one-cycle integration strobe from the upstream timebase.
REQ-007 SHALL have port current_in, input, 8: unsigned input current, sampled only on step_en.
REQ-008 SHALL have port thresh_in, input, 8: runtime threshold; 0 selects THRESHOLD.
REQ-009 SHALL have port spike, output, 1: registered one-cycle fire pulse.
REQ-010 SHALL have port membrane, output, 8: current membrane potential register.
REQ-011 SHALL have port refractory, output, 1: high while in REFRACT state.
REQ-012 SHALL have port spike_count, output, 4: decimal spike counter 0..9 for the downstream 7-segment display stage.

Function
REQ-013 SHALL implement three states: INTEGRATE, FIRE, REFRACT.
REQ-014 SHALL, in INTEGRATE on step_en, compute next = membrane - (membrane >> LEAK_SHIFT) + current_in in 9 bits, saturating to 255.
REQ-015 SHALL use thr = (thresh_in == 0) ? THRESHOLD : thresh_in, evaluated in the same cycle as the step_en sample.
REQ-016 SHALL, if next >= thr, load membrane <= 0 and enter FIRE on the next edge; otherwise load membrane <= next and remain in INTEGRATE.
REQ-017 SHALL assert spike exactly during the FIRE state (one cycle, asserted on the edge after the triggering step_en).
REQ-018 SHALL increment spike_count on entry to FIRE, wrapping 9 -> 0.
REQ-019 SHALL leave FIRE after one cycle: to REFRACT with a 4-bit refract counter loaded with REFRACT_STEPS, or directly to INTEGRATE when REFRACT_STEPS == 0.
REQ-020 SHALL ignore step_en and current_in during FIRE.
REQ-021 SHALL, in REFRACT, hold membrane at 0, ignore current_in, and decrement the refract counter on each step_en.
REQ-022 SHALL return to INTEGRATE on the step_en that decrements the counter from 1 to 0; that step's current is not integrated.
REQ-023 SHALL leave membrane and state unchanged in cycles without step_en.
REQ-024 SHALL treat thresh_in == 1 with current_in >= 1 as an immediate fire; no input combination may cause membrane wrap-around.
REQ-025 SHALL give reset priority over step_en in the same cycle.

Reset
REQ-026 SHALL, on reset, set state = INTEGRATE, membrane = 0, spike = 0, refractory = 0, spike_count = 0, refract counter = 0.
REQ-027 SHALL, on reset asserted mid-FIRE or mid-REFRACT, abort the current state; the first step_en after reset deasserts integrates normally.

Verification
REQ-028 SHALL verify: current_in = 0, 20 strobes -> membrane stays 0, spike never asserts.
REQ-029 SHALL verify: thresh_in = 0, current_in = 50, defaults -> membrane 50, 94, 133, 167, 197, then a spike one cycle after the 6th strobe, membrane = 0, spike_count = 1.
REQ-030 SHALL verify: thresh_in = 255, current_in = 255 -> 9-bit sum saturates to 255 >= 255 -> spike after the first strobe.
REQ-031 SHALL verify: after a spike with REFRACT_STEPS = 2 -> refractory = 1 and membrane = 0 for 2 strobes; the 3rd strobe integrates current_in.
REQ-032 SHALL verify: 10 spikes -> spike_count runs 1..9 then wraps to 0.
REQ-033 SHALL verify: reset asserted during REFRACT together with step_en -> all outputs 0, state INTEGRATE; the next strobe with current_in = 50 gives membrane = 50.
